// File: rtl/periph_bus_resp.sv
// Memory-mapped peripheral responder: LED, 7-seg, switches, systick and an optional timer.
// Timer hardware (TH/TL/TCON, oIrq) is compiled in only when PERIPH_TIMER_EN is defined.
module periph_bus_resp (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLed,
  output logic [11:0] oDigi,
  output logic        oIrq
);

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SWITCH,
    SEL_DIGI,
    SEL_SYSTICK
  } sel_t;

  sel_t        sel;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [31:0] systick;
  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] th_rd;
  logic [31:0] tl_rd;
  logic [2:0]  tcon_rd;
  logic [31:0] rd_data;

  // Full 32-bit compare; misaligned addresses never select a register.
  always_comb begin
    sel = SEL_NONE;
    if (iAddr[1:0] == 2'b00) begin
      case (iAddr)
        ADDR_TH:      sel = SEL_TH;
        ADDR_TL:      sel = SEL_TL;
        ADDR_TCON:    sel = SEL_TCON;
        ADDR_LED:     sel = SEL_LED;
        ADDR_SWITCH:  sel = SEL_SWITCH;
        ADDR_DIGI:    sel = SEL_DIGI;
        ADDR_SYSTICK: sel = SEL_SYSTICK;
        default:      sel = SEL_NONE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      led     <= '0;
      digi    <= '0;
      systick <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      systick <= systick + 32'd1;
      sw_meta <= iSwitch;
      sw_sync <= sw_meta;
      if (iMemWrite && sel == SEL_LED)  led  <= iWrData[7:0];
      if (iMemWrite && sel == SEL_DIGI) digi <= iWrData[11:0];
    end
  end

`ifdef PERIPH_TIMER_EN
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic        tl_wrap;
  logic        irq_set;

  assign tl_wrap = tcon[0] && (tl == '1);
  assign irq_set = tl_wrap && tcon[1];

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (iMemWrite && sel == SEL_TH) th <= iWrData;
      if (iMemWrite && sel == SEL_TL) begin
        tl <= iWrData;
      end else if (tcon[0]) begin
        tl <= tl_wrap ? th : tl + 32'd1;
      end
      // Hardware set of the status bit beats a concurrent software clear.
      if (iMemWrite && sel == SEL_TCON) begin
        tcon <= {iWrData[2] | irq_set, iWrData[1:0]};
      end else if (irq_set) begin
        tcon[2] <= 1'b1;
      end
    end
  end

  assign th_rd   = th;
  assign tl_rd   = tl;
  assign tcon_rd = tcon;
  assign oIrq    = tcon[2];
`else
  logic unused_wr_bits;

  assign unused_wr_bits = ^iWrData[31:12];
  assign th_rd   = '0;
  assign tl_rd   = '0;
  assign tcon_rd = '0;
  assign oIrq    = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (iMemRead) begin
      case (sel)
        SEL_TH:      rd_data = th_rd;
        SEL_TL:      rd_data = tl_rd;
        SEL_TCON:    rd_data = {29'd0, tcon_rd};
        SEL_LED:     rd_data = {24'd0, led};
        SEL_SWITCH:  rd_data = {24'd0, sw_sync};
        SEL_DIGI:    rd_data = {20'd0, digi};
        SEL_SYSTICK: rd_data = systick;
        default:     rd_data = '0;
      endcase
    end
  end

  assign oRdData = rd_data;
  assign oLed    = led;
  assign oDigi   = digi;

endmodule
